av2_recon_frame_writer: RTL and testbench

AV2_RECON_FRAME_WRITER -- requirements
Module: av2_recon_frame_writer

---
 rtl/av2_pkg.sv | 15 +
 rtl/av2_sync_fifo.sv | 72 +++++++
 rtl/av2_recon_frame_writer.sv | 112 +++++++++++
 tb/tb_av2_recon_frame_writer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/av2_pkg.sv
// Shared constants and writer FSM state type for the AV2 reconstruction frame writer.
// A reconstruction word is 16 pixels of 8 bits and covers 16 bytes of the frame buffer.
package av2_pkg;

    localparam int unsigned RECON_WORD_W     = 128;
    localparam int unsigned RECON_WORD_BYTES = 16;
    localparam int unsigned RECON_WORD_SHIFT = $clog2(RECON_WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } wr_state_e;

endpackage

// File: rtl/av2_sync_fifo.sv
// Single-clock FIFO with registered push/pop, power-of-two depth and an explicit
// occupancy count used to tell full from empty.
module av2_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        full  = (level_q == LVL_W'(DEPTH));
        empty = (level_q == '0);
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        wr_en = push && (!full || pop);
        rd_en = pop && !empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;

endmodule

// File: rtl/av2_recon_frame_writer.sv
// Buffers reconstruction words from the tile decoder and writes them to the frame
// buffer one request at a time, signalling flush_done once a finished tile has drained.
module av2_recon_frame_writer
    import av2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [127:0]                  recon_data,
    input  logic [ADDR_W-1:0]             recon_addr,
    input  logic                          recon_wr_en,
    input  logic                          tile_done,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [127:0]                  mem_wdata,
    input  logic                          mem_gnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          flush_done
);

    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDR_W + RECON_WORD_W;

    wr_state_e          state_q, state_d;
    logic               flush_pend_q, flush_pend_d;
    logic               overflow_q, overflow_d;

    logic [ENTRY_W-1:0]      head;
    logic [ADDR_W-1:0]       head_addr;
    logic [RECON_WORD_W-1:0] head_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;

    av2_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (recon_wr_en),
        .push_data ({recon_addr, recon_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign head_addr = head[ENTRY_W-1 -: ADDR_W];
    assign head_data = head[RECON_WORD_W-1:0];

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q | tile_done;
        overflow_d   = overflow_q | (recon_wr_en && fifo_full && !pop);
        pop          = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        flush_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = REQ;
                end else if (flush_pend_q) begin
                    state_d = DONE;
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_addr  = base_addr + (head_addr << RECON_WORD_SHIFT);
                mem_wdata = head_data;
                if (mem_gnt) begin
                    pop = 1'b1;
                    // A word pushed this cycle keeps the request stream going.
                    if ((fifo_level > LVL_W'(1)) || recon_wr_en) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                flush_done   = 1'b1;
                flush_pend_d = tile_done;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_av2_recon_frame_writer.sv
// Scoreboard bench for av2_recon_frame_writer: directed scenarios followed by random traffic,
// with a queue model of the buffer checked by an independent monitor.
module tb_av2_recon_frame_writer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 32;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [127:0]   recon_data = '0;
    logic [AW-1:0]  recon_addr = '0;
    logic           recon_wr_en = 1'b0;
    logic           tile_done = 1'b0;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic [127:0]   mem_wdata;
    logic           mem_gnt = 1'b0;
    logic [LW-1:0]  fifo_level;
    logic           overflow;
    logic           flush_done;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [127:0]  data;
    } word_t;

    word_t          exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             lvl = 0;
    bit             ovf = 1'b0;
    int             mcyc = 0;
    int             last_hs_cyc = 0;
    int             flush_cnt = 0;
    int             flush_cyc = 0;
    logic [AW-1:0]  last_hs_addr = '0;

    av2_recon_frame_writer #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .base_addr   (base_addr),
        .recon_data  (recon_data),
        .recon_addr  (recon_addr),
        .recon_wr_en (recon_wr_en),
        .tile_done   (tile_done),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .flush_done  (flush_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted request against the scoreboard and tracks the model.
    bit    hs;
    int    pre;
    word_t w;
    word_t nw;
    logic [AW-1:0] ea;
    always @(negedge clk) begin
        if (rst_n) begin
            mcyc++;
            chk("fifo_level", fifo_level, lvl);
            chk("overflow", overflow, ovf);
            hs  = mem_req && mem_gnt;
            pre = lvl;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got request addr %0h, expected none", mem_addr);
                end else begin
                    w  = exp_q.pop_front();
                    ea = base_addr + w.addr * 32'd16;
                    chk("mem_addr", mem_addr, ea);
                    chk("mem_wdata", mem_wdata, w.data);
                    lvl--;
                end
                last_hs_cyc  = mcyc;
                last_hs_addr = mem_addr;
            end
            if (flush_done) begin
                flush_cnt++;
                flush_cyc = mcyc;
            end
            if (recon_wr_en) begin
                if (pre < int'(DEPTH) || hs) begin
                    nw.addr = recon_addr;
                    nw.data = recon_data;
                    exp_q.push_back(nw);
                    lvl++;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        recon_wr_en = 1'b0;
        tile_done   = 1'b0;
    endtask

    task automatic drive_wr(input logic [AW-1:0] a, input logic [127:0] d);
        recon_wr_en = 1'b1;
        recon_addr  = a;
        recon_data  = d;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write, grant tied high: request two cycles after the push
        base_addr = 32'h1000;
        mem_gnt   = 1'b1;
        step();
        drive_wr(32'd3, 128'h0F0E0D0C0B0A09080706050403020100);
        @(negedge clk);
        chk("t1_req_N", mem_req, 0);
        step();
        @(negedge clk);
        chk("t1_req_N1", mem_req, 0);
        step();
        @(negedge clk);
        chk("t1_req_N2", mem_req, 1);
        chk("t1_addr", mem_addr, 32'h1030);
        chk("t1_data", mem_wdata, 128'h0F0E0D0C0B0A09080706050403020100);
        step();
        step();
        @(negedge clk);
        chk("t1_level", fifo_level, 0);
        chk("t1_idle", mem_req, 0);

        // Eight writes stalled for 20 cycles, then drained back-to-back
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_wr(32'(16 + i), rnd128());
            step();
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t2_hold_req", mem_req, 1);
            chk("t2_hold_addr", mem_addr, 32'h1100);
            step();
        end
        @(negedge clk);
        chk("t2_level_full", fifo_level, 8);
        chk("t2_no_ovf", overflow, 0);
        step();
        mem_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_b2b_req", mem_req, 1);
            chk("t2_b2b_addr", mem_addr, 32'h1000 + 32'(16 + i) * 32'd16);
            step();
        end
        @(negedge clk);
        chk("t2_after_idle", mem_req, 0);

        // Nine writes into a stalled FIFO: the ninth is dropped and overflow sticks
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_wr(32'(32 + i), rnd128());
            step();
        end
        step();
        @(negedge clk);
        chk("t3_ovf", overflow, 1);
        chk("t3_level", fifo_level, 8);
        step();
        mem_gnt = 1'b1;
        repeat (12) step();
        @(negedge clk);
        chk("t3_level_drained", fifo_level, 0);
        chk("t3_ovf_sticky", overflow, 1);
        step();
        chk("t3_scoreboard_empty", exp_q.size(), 0);

        // Full FIFO with push and grant together: level unchanged, new word last
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_wr(32'(48 + i), rnd128());
            step();
        end
        step();
        step();
        drive_wr(32'd99, rnd128());
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("t4_level_full", fifo_level, 8);
        step();
        mem_gnt = 1'b1;
        repeat (12) step();
        chk("t4_last_addr", last_hs_addr, 32'h1630);
        chk("t4_scoreboard_empty", exp_q.size(), 0);

        // tile_done with the last write, a repeat tile_done, grant toggling
        flush_cnt = 0;
        mem_gnt   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            mem_gnt = (c % 2 == 1);
            if (c < 4) drive_wr(32'(64 + c), rnd128());
            if (c == 3 || c == 5) tile_done = 1'b1;
        end
        repeat (4) step();
        chk("t5_flush_count", flush_cnt, 1);
        chk("t5_flush_timing", flush_cyc - last_hs_cyc, 2);
        chk("t5_scoreboard_empty", exp_q.size(), 0);

        // Asynchronous reset while requesting with five entries buffered
        mem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_wr(32'(80 + i), rnd128());
            step();
        end
        step();
        step();
        @(negedge clk);
        chk("t6_pre_req", mem_req, 1);
        step();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        lvl = 0;
        ovf = 1'b0;
        #1;
        chk("t6_rst_req", mem_req, 0);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_wdata", mem_wdata, 0);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_flush", flush_done, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_no_req", mem_req, 0);
            step();
        end
        drive_wr(32'd5, rnd128());
        step();
        step();
        @(negedge clk);
        chk("t6_new_req", mem_req, 1);
        chk("t6_new_addr", mem_addr, 32'h1050);
        step();
        repeat (3) step();

        // Random traffic: slow grants first to hit full/drop, then fast grants
        base_addr = $urandom;
        for (int c = 0; c < 400; c++) begin
            step();
            if ($urandom_range(0, 1) == 1) drive_wr($urandom, rnd128());
            tile_done = ($urandom_range(0, 19) == 0);
            if (c < 200) mem_gnt = ($urandom_range(0, 3) == 0);
            else         mem_gnt = ($urandom_range(0, 3) != 0);
        end
        step();
        mem_gnt = 1'b1;
        repeat (20) step();
        chk("rnd_scoreboard_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("rnd_level_drained", fifo_level, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
